alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Control-side counterpart of the 16-bit ALU: fetches instructions over a request/valid handshake, decodes them and reads an internal 8x16 register file.
- Drives the ALU operand/opcode/select inputs, then writes the ALU result and flags back.
- Sits between instruction memory and the combinational ALU, and forms the core sequencing loop of the CPU.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NREGS, 8, register file depth (fixed at 8; rd/rs fields are 3 bits).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held until imem_valid
- imem_addr  out  16  fetch address (PC)
- imem_valid  in  1  imem_data valid this cycle
- imem_data  in  16  instruction or immediate word
- alu_op1  out  16  ALU operand 1
- alu_op2  out  16  ALU operand 2
- alu_opcode  out  4  ALU opcode
- alu_ot  out  2  ALU output-type select (00 addressing, 01 arith, 10 logic)
- alu_out  in  16  ALU result
- alu_addr  in  16  ALU address result
- alu_za, alu_zb, alu_eq, alu_gt, alu_lt  in  1 each  ALU flags
- flags  out  5  latched {za,zb,eq,gt,lt}
- addr_reg  out  16  last latched alu_addr
- halted  out  1  high in HALT state
- retired  out  16  count of retired instructions

Behaviour:
- Instruction format: [15:14] ot, [13:10] opcode, [9:7] rd, [6:4] rs1, [3:1] rs2, [0] ignored.
- Reset (rst high at a clk edge): state=FETCH, PC=RESET_PC, all regs=0, flags=0, addr_reg=0, retired=0, alu_* outputs=0, halted=0. While rst is high, imem_req=0.
- Reset mid-operation: the in-flight instruction is abandoned with no writeback.
- imem_req = (state==FETCH or FETCH_IMM) and not rst. imem_addr = PC.
- FETCH:
  - wait while imem_valid=0.
  - On imem_valid=1, latch IR=imem_data, PC<=PC+1, go to DECODE.
  - Fetch latency is 1 cycle minimum; imem_valid on the first req cycle is legal.
- DECODE:
  - ot in {00,01,10}: register alu_op1=R[rs1], alu_op2=R[rs2], alu_opcode, alu_ot. Go to EXEC.
  - ot=11, opcode=F: go to HALT.
  - ot=11, opcode=1 (LDI): go to FETCH_IMM.
  - ot=11, any other opcode: NOP. retired++ and go to FETCH; no register or flag change.
- FETCH_IMM: on imem_valid=1, R[rd]<=imem_data (unless rd=0), PC<=PC+1, retired++, go to FETCH. Flags are unchanged.
- EXEC: one settle cycle for the combinational ALU; alu_* outputs held stable. Go to WB.
- WB:
  - R[rd]<=alu_out unless rd=0.
  - flags<={alu_za,alu_zb,alu_eq,alu_gt,alu_lt}.
  - if ot=00, addr_reg<=alu_addr.
  - retired++, go to FETCH.
- alu_* outputs hold their value outside DECODE.
- R0 is hardwired to 0: writes are discarded and reads return 0.
- Read-after-write is safe: every instruction completes WB before the next DECODE, so no forwarding is needed.
- ALU instruction timing: 4 cycles with a zero-wait fetch (FETCH, DECODE, EXEC, WB). LDI: 3 cycles (FETCH, DECODE, FETCH_IMM).
- PC and retired wrap FFFF->0000 silently.
- HALT: halted=1, imem_req=0, all state frozen; left only by rst.

Test Plan:
- Reset then zero-wait memory: imem_req=1 with imem_addr=0000 in the first cycle after rst deasserts; halted=0; flags=0.
- LDI: LDI R1 followed by immediate 0x1234, then LDI R2 followed by 0x0005 → R1=1234, R2=0005, PC=4, retired=2, flags unchanged.
- ALU op: ot=01, opcode=0, rd=3, rs1=1, rs2=2 with the bench ALU model out=op1+op2 and eq=0, gt=1 → alu_op1=1234, alu_op2=0005 during EXEC; R3=1239 and flags=00010 after WB; exactly 4 cycles from req to next req.
- Wait states plus R0: imem_valid delayed 3 cycles → imem_req and imem_addr held stable throughout; LDI R0 with 0xFFFF → R0 still reads 0 as alu_op1.
- HALT and mid-op reset: fetch 0xFC00 (ot=11, opcode=F) → halted=1 and imem_req=0 for 10+ cycles; separately, assert rst during EXEC → no writeback, PC=0, retired=0.
- Wrap: RESET_PC=FFFF with a NOP at FFFF → next imem_addr=0000, retired=1.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: control sequencer for the 16-bit combinational ALU.
// It fetches instructions over a req/valid handshake, decodes them and reads
// an internal 8x16 register file. It then drives the ALU operand, opcode and
// output-type inputs, and writes the ALU result and flags back.
//
// Instruction word: [15:14] ot, [13:10] opcode, [9:7] rd, [6:4] rs1, [3:1] rs2.
//   ot 00/01/10 : ALU op, FETCH -> DECODE -> EXEC -> WB
//   ot 11, op F : HALT (left only by rst)
//   ot 11, op 1 : LDI, next word is the immediate for R[rd]
//   ot 11, else : NOP
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   imem_req/imem_addr    fetch request (held until imem_valid), address = PC
//   imem_valid/imem_data  fetch response
//   alu_op1/op2/opcode/ot registered ALU inputs, loaded in DECODE only
//   alu_out/alu_addr      ALU results
//   alu_za..alu_lt        ALU flags
//   flags                 latched {za,zb,eq,gt,lt}
//   addr_reg              last latched alu_addr (ot=00 instructions)
//   halted                high in HALT
//   retired               retired-instruction count (wraps)
module alu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          NREGS    = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic [15:0] alu_op1,
  output logic [15:0] alu_op2,
  output logic [3:0]  alu_opcode,
  output logic [1:0]  alu_ot,
  input  logic [15:0] alu_out,
  input  logic [15:0] alu_addr,
  input  logic        alu_za,
  input  logic        alu_zb,
  input  logic        alu_eq,
  input  logic        alu_gt,
  input  logic        alu_lt,
  output logic [4:0]  flags,
  output logic [15:0] addr_reg,
  output logic        halted,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_FETCH_IMM = 3'd2,
    S_EXEC      = 3'd3,
    S_WB        = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [1:0] OT_ADDR = 2'b00;
  localparam logic [1:0] OT_CTRL = 2'b11;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state_q, state_d;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [15:0] regs [NREGS];

  // Bit 0 of the instruction word carries no meaning.
  logic unused_ir_bit;
  assign unused_ir_bit = ir[0];

  logic [1:0] ir_ot;
  logic [3:0] ir_op;
  logic [2:0] ir_rd, ir_rs1, ir_rs2;
  assign ir_ot  = ir[15:14];
  assign ir_op  = ir[13:10];
  assign ir_rd  = ir[9:7];
  assign ir_rs1 = ir[6:4];
  assign ir_rs2 = ir[3:1];

  // R0 reads as zero regardless of storage contents.
  logic [15:0] rs1_val, rs2_val;
  assign rs1_val = (ir_rs1 == 3'd0) ? 16'h0000 : regs[ir_rs1];
  assign rs2_val = (ir_rs2 == 3'd0) ? 16'h0000 : regs[ir_rs2];

  assign imem_req  = ((state_q == S_FETCH) || (state_q == S_FETCH_IMM)) && !rst;
  assign imem_addr = pc;
  assign halted    = (state_q == S_HALT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (imem_valid) state_d = S_DECODE;
      S_DECODE: begin
        if (ir_ot != OT_CTRL)     state_d = S_EXEC;
        else if (ir_op == OP_HALT) state_d = S_HALT;
        else if (ir_op == OP_LDI)  state_d = S_FETCH_IMM;
        else                       state_d = S_FETCH;
      end
      S_FETCH_IMM: if (imem_valid) state_d = S_FETCH;
      S_EXEC:      state_d = S_WB;
      S_WB:        state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  // Datapath. A reset while an instruction is in flight simply clears
  // everything, so the abandoned instruction never reaches WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      ir         <= '0;
      flags      <= '0;
      addr_reg   <= '0;
      retired    <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_opcode <= '0;
      alu_ot     <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_valid) begin
            ir <= imem_data;
            pc <= pc + 16'd1;
          end
        end
        S_DECODE: begin
          // ALU inputs change only here, so they are stable through EXEC/WB.
          if (ir_ot != OT_CTRL) begin
            alu_op1    <= rs1_val;
            alu_op2    <= rs2_val;
            alu_opcode <= ir_op;
            alu_ot     <= ir_ot;
          end else if (ir_op != OP_HALT && ir_op != OP_LDI) begin
            retired <= retired + 16'd1;
          end
        end
        S_FETCH_IMM: begin
          if (imem_valid) begin
            if (ir_rd != 3'd0) regs[ir_rd] <= imem_data;
            pc      <= pc + 16'd1;
            retired <= retired + 16'd1;
          end
        end
        S_WB: begin
          if (ir_rd != 3'd0) regs[ir_rd] <= alu_out;
          flags <= {alu_za, alu_zb, alu_eq, alu_gt, alu_lt};
          if (ir_ot == OT_ADDR) addr_reg <= alu_addr;
          retired <= retired + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
